// File: rtl/alu_seq_unit.sv
// WIDTH-bit ALU with registered results over a valid/ready handshake.
// Single-cycle logic/arith/shift ops, plus iterative unsigned multiply and restoring divide.
`timescale 1ns/1ps
module alu_seq_unit #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUOp,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Hi,
    output logic             Zero,
    output logic             Overflow,
    output logic             CarryOut
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_MULU = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] work_hi_q, work_hi_d;
    logic [WIDTH-1:0] work_lo_q, work_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             cout_q, cout_d;

    logic [WIDTH:0]   add_sum, sub_sum;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf, alu_cout, alu_known;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_sub;
    logic             div_ge;
    logic [WIDTH-1:0] iter_hi, iter_lo;
    logic             start_op;

    assign InReady  = (state_q == IDLE) || ((state_q == DONE) && OutReady);
    assign OutValid = (state_q == DONE);
    assign Result   = result_q;
    assign Hi       = hi_q;
    assign Zero     = zero_q;
    assign Overflow = ovf_q;
    assign CarryOut = cout_q;

    // Single-cycle datapath; SUB is A + ~B + 1 so its carry means "no borrow".
    always_comb begin
        add_sum    = {1'b0, A} + {1'b0, B};
        sub_sum    = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
        shamt      = B[SHW-1:0];
        alu_result = '0;
        alu_ovf    = 1'b0;
        alu_cout   = 1'b0;
        alu_known  = 1'b1;
        case (ALUOp)
            OP_AND:  alu_result = A & B;
            OP_OR:   alu_result = A | B;
            OP_ADD: begin
                alu_result = add_sum[WIDTH-1:0];
                alu_cout   = add_sum[WIDTH];
                alu_ovf    = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_result = sub_sum[WIDTH-1:0];
                alu_cout   = sub_sum[WIDTH];
                alu_ovf    = (A[WIDTH-1] != B[WIDTH-1]) && (sub_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_XOR:  alu_result = A ^ B;
            OP_NOR:  alu_result = ~(A | B);
            OP_SLL:  alu_result = A << shamt;
            OP_SRL:  alu_result = A >> shamt;
            OP_SRA:  alu_result = WIDTH'($signed(A) >>> shamt);
            default: alu_known  = 1'b0;
        endcase
    end

    // One multiply or divide step; both keep {remainder/high, quotient/low} in the work pair.
    always_comb begin
        mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_sub   = div_shift[WIDTH-1:0] - opnd_q;
        if (is_div_q) begin
            iter_hi = div_ge ? div_sub : div_shift[WIDTH-1:0];
            iter_lo = {work_lo_q[WIDTH-2:0], div_ge};
        end else begin
            iter_hi = mul_sum[WIDTH:1];
            iter_lo = {mul_sum[0], work_lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        result_d  = result_q;
        hi_d      = hi_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        cout_d    = cout_q;
        start_op  = 1'b0;
        case (state_q)
            IDLE: start_op = InValid;
            BUSY: begin
                work_hi_d = iter_hi;
                work_lo_d = iter_lo;
                cnt_d     = cnt_q + SHW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d  = DONE;
                    result_d = iter_lo;
                    hi_d     = iter_hi;
                    zero_d   = (iter_lo == '0);
                    ovf_d    = is_div_q && (opnd_q == '0);
                    cout_d   = 1'b0;
                end
            end
            DONE: begin
                if (OutReady) begin
                    state_d  = IDLE;
                    start_op = InValid;
                end
            end
            default: state_d = IDLE;
        endcase
        // A back-to-back accept from DONE takes the same path as one from IDLE.
        if (start_op) begin
            if ((ALUOp == OP_MULU) || (ALUOp == OP_DIVU)) begin
                state_d   = BUSY;
                cnt_d     = '0;
                is_div_d  = (ALUOp == OP_DIVU);
                work_hi_d = '0;
                work_lo_d = (ALUOp == OP_DIVU) ? A : B;
                opnd_d    = (ALUOp == OP_DIVU) ? B : A;
            end else begin
                state_d  = DONE;
                result_d = alu_result;
                hi_d     = '0;
                zero_d   = alu_known && (alu_result == '0);
                ovf_d    = alu_ovf;
                cout_d   = alu_cout;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            result_q  <= '0;
            hi_q      <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            result_q  <= result_d;
            hi_q      <= hi_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            cout_q    <= cout_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed-vector bench for alu_seq_unit at WIDTH=16 with hand-computed expectations.
`timescale 1ns/1ps
module tb_alu_seq_unit;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [3:0]  ALUOp = '0;
    logic        OutValid;
    logic        OutReady = 1'b1;
    logic [15:0] Result;
    logic [15:0] Hi;
    logic        Zero;
    logic        Overflow;
    logic        CarryOut;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
    } vec_t;

    alu_seq_unit #(.WIDTH(16), .SHW(4)) dut (
        .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .A(A), .B(B), .ALUOp(ALUOp), .OutValid(OutValid), .OutReady(OutReady),
        .Result(Result), .Hi(Hi), .Zero(Zero), .Overflow(Overflow), .CarryOut(CarryOut)
    );

    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        InValid = 1'b1;
        ALUOp   = op;
        A       = a;
        B       = b;
        step();
        InValid = 1'b0;
    endtask

    // Accepts a multi-cycle op, scrambles inputs, and measures cycles until OutValid.
    task automatic run_multi(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                             output int lat, output logic busy_ready_low);
        lat = 99;
        busy_ready_low = 1'b1;
        issue(op, a, b);
        A = 16'hFFFF;
        B = 16'hFFFF;
        for (int n = 1; n <= 40; n++) begin
            if (OutValid) begin
                lat = n;
                break;
            end
            if (InReady !== 1'b0) busy_ready_low = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        checks++;
        if ({OutValid, InReady, Zero, Overflow, CarryOut} !== 5'b01000) begin
            failures++;
            $display("[TB] FAIL reset_flags got=%b exp=01000", {OutValid, InReady, Zero, Overflow, CarryOut});
        end
        checks++;
        if ({Result, Hi} !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_data got=%h exp=00000000", {Result, Hi});
        end
    endtask

    task automatic test_add_sub();
        issue(4'd2, 16'h7FFF, 16'h0001);
        checks++;
        if ({OutValid, Result, Hi, Overflow, CarryOut, Zero} !== {1'b1, 16'h8000, 16'h0000, 3'b100}) begin
            failures++;
            $display("[TB] FAIL add_ovf got v=%b r=%h hi=%h o=%b c=%b z=%b exp v=1 r=8000 hi=0000 o=1 c=0 z=0",
                     OutValid, Result, Hi, Overflow, CarryOut, Zero);
        end
        step();
        issue(4'd2, 16'hFFFF, 16'h0001);
        checks++;
        if ({Result, Overflow, CarryOut, Zero} !== {16'h0000, 3'b011}) begin
            failures++;
            $display("[TB] FAIL add_carry got r=%h o=%b c=%b z=%b exp r=0000 o=0 c=1 z=1", Result, Overflow, CarryOut, Zero);
        end
        step();
        issue(4'd3, 16'h0005, 16'h0005);
        checks++;
        if ({Result, Overflow, CarryOut, Zero} !== {16'h0000, 3'b011}) begin
            failures++;
            $display("[TB] FAIL sub_equal got r=%h o=%b c=%b z=%b exp r=0000 o=0 c=1 z=1", Result, Overflow, CarryOut, Zero);
        end
        step();
        issue(4'd3, 16'h0003, 16'h0005);
        checks++;
        if ({Result, Overflow, CarryOut, Zero} !== {16'hFFFE, 3'b000}) begin
            failures++;
            $display("[TB] FAIL sub_borrow got r=%h o=%b c=%b z=%b exp r=FFFE o=0 c=0 z=0", Result, Overflow, CarryOut, Zero);
        end
        step();
        issue(4'd3, 16'h8000, 16'h0001);
        checks++;
        if ({Result, Overflow, CarryOut} !== {16'h7FFF, 2'b11}) begin
            failures++;
            $display("[TB] FAIL sub_ovf got r=%h o=%b c=%b exp r=7FFF o=1 c=1", Result, Overflow, CarryOut);
        end
        step();
    endtask

    task automatic test_logic_shift();
        vec_t vecs [13];
        vecs[0]  = '{4'd4, 16'h8000, 16'h0001, 16'h0001};
        vecs[1]  = '{4'd4, 16'h7FFF, 16'h8000, 16'h0000};
        vecs[2]  = '{4'd4, 16'h8000, 16'h7FFF, 16'h0001};
        vecs[3]  = '{4'd9, 16'h8004, 16'h0002, 16'hE001};
        vecs[4]  = '{4'd8, 16'h8004, 16'h0002, 16'h2001};
        vecs[5]  = '{4'd8, 16'h8004, 16'h0012, 16'h2001};
        vecs[6]  = '{4'd7, 16'h0001, 16'h0004, 16'h0010};
        vecs[7]  = '{4'd7, 16'h1234, 16'h0000, 16'h1234};
        vecs[8]  = '{4'd0, 16'hF0F0, 16'hFF00, 16'hF000};
        vecs[9]  = '{4'd1, 16'hF0F0, 16'hFF00, 16'hFFF0};
        vecs[10] = '{4'd5, 16'hF0F0, 16'hFF00, 16'h0FF0};
        vecs[11] = '{4'd6, 16'hF0F0, 16'h0F00, 16'h000F};
        vecs[12] = '{4'd12, 16'h1234, 16'h5678, 16'h0000};
        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            checks++;
            if ({OutValid, Result, Hi, Overflow, CarryOut} !== {1'b1, vecs[i].r, 16'h0000, 2'b00}) begin
                failures++;
                $display("[TB] FAIL vec%0d op=%0d got v=%b r=%h hi=%h o=%b c=%b exp v=1 r=%h hi=0000 o=0 c=0",
                         i, vecs[i].op, OutValid, Result, Hi, Overflow, CarryOut, vecs[i].r);
            end
            step();
        end
    endtask

    task automatic test_muldiv();
        int   lat;
        logic rdy_low;
        run_multi(4'd10, 16'h1234, 16'h5678, lat, rdy_low);
        checks++;
        if (lat != 17 || rdy_low !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mulu_timing got lat=%0d inready_low=%b exp lat=17 inready_low=1", lat, rdy_low);
        end
        checks++;
        if ({Hi, Result, Zero, Overflow, CarryOut} !== {16'h0626, 16'h0060, 3'b000}) begin
            failures++;
            $display("[TB] FAIL mulu_result got hi=%h r=%h z=%b o=%b c=%b exp hi=0626 r=0060 flags=000",
                     Hi, Result, Zero, Overflow, CarryOut);
        end
        step();
        run_multi(4'd10, 16'hFFFF, 16'hFFFF, lat, rdy_low);
        checks++;
        if ({Hi, Result} !== 32'hFFFE0001 || lat != 17) begin
            failures++;
            $display("[TB] FAIL mulu_max got hi=%h r=%h lat=%0d exp hi=FFFE r=0001 lat=17", Hi, Result, lat);
        end
        step();
        run_multi(4'd11, 16'h0064, 16'h0007, lat, rdy_low);
        checks++;
        if ({Result, Hi, Overflow, Zero} !== {16'h000E, 16'h0002, 2'b00} || lat != 17 || rdy_low !== 1'b1) begin
            failures++;
            $display("[TB] FAIL divu_basic got r=%h hi=%h o=%b z=%b lat=%0d exp r=000E hi=0002 o=0 z=0 lat=17",
                     Result, Hi, Overflow, Zero, lat);
        end
        step();
        run_multi(4'd11, 16'h1234, 16'h0000, lat, rdy_low);
        checks++;
        if ({Result, Hi, Overflow} !== {16'hFFFF, 16'h1234, 1'b1} || lat != 17) begin
            failures++;
            $display("[TB] FAIL divu_by_zero got r=%h hi=%h o=%b lat=%0d exp r=FFFF hi=1234 o=1 lat=17",
                     Result, Hi, Overflow, lat);
        end
        step();
        run_multi(4'd11, 16'h0003, 16'h0009, lat, rdy_low);
        checks++;
        if ({Result, Hi, Zero} !== {16'h0000, 16'h0003, 1'b1}) begin
            failures++;
            $display("[TB] FAIL divu_small got r=%h hi=%h z=%b exp r=0000 hi=0003 z=1", Result, Hi, Zero);
        end
        step();
    endtask

    task automatic test_back_pressure();
        logic held_ok;
        held_ok  = 1'b1;
        OutReady = 1'b0;
        issue(4'd2, 16'h0001, 16'h0002);
        InValid = 1'b1;
        ALUOp   = 4'd3;
        A       = 16'h0010;
        B       = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            if ({OutValid, InReady, Result} !== {1'b1, 1'b0, 16'h0003}) held_ok = 1'b0;
            step();
        end
        checks++;
        if (held_ok !== 1'b1 || {OutValid, Result} !== {1'b1, 16'h0003}) begin
            failures++;
            $display("[TB] FAIL backpressure_hold got held_ok=%b v=%b r=%h exp held_ok=1 v=1 r=0003",
                     held_ok, OutValid, Result);
        end
        OutReady = 1'b1;
        #1;
        checks++;
        if (InReady !== 1'b1) begin
            failures++;
            $display("[TB] FAIL backpressure_inready got=%b exp=1", InReady);
        end
        step();
        InValid = 1'b0;
        checks++;
        if ({OutValid, Result, CarryOut} !== {1'b1, 16'h000F, 1'b1}) begin
            failures++;
            $display("[TB] FAIL backpressure_accept got v=%b r=%h c=%b exp v=1 r=000F c=1", OutValid, Result, CarryOut);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_r [3];
        logic        ok;
        ok       = 1'b1;
        exp_r[0] = 16'h00FF;
        exp_r[1] = 16'h0F0F;
        exp_r[2] = 16'hFFFF;
        InValid = 1'b1;
        ALUOp   = 4'd5;
        B       = 16'h00FF;
        for (int i = 0; i < 3; i++) begin
            A = (i == 0) ? 16'h0000 : (i == 1) ? 16'h0FF0 : 16'hFF00;
            step();
            if ({OutValid, Result} !== {1'b1, exp_r[i]}) begin
                ok = 1'b0;
                $display("[TB] FAIL back_to_back_%0d got v=%b r=%h exp v=1 r=%h", i, OutValid, Result, exp_r[i]);
            end
        end
        InValid = 1'b0;
        checks++;
        if (ok !== 1'b1) failures++;
        step();
        checks++;
        if ({OutValid, InReady} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL back_to_back_drain got v=%b rdy=%b exp v=0 rdy=1", OutValid, InReady);
        end
    endtask

    task automatic test_reset_mid_mul();
        issue(4'd10, 16'h1234, 16'h5678);
        step();
        step();
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checks++;
        if ({OutValid, InReady, Zero, Overflow, CarryOut, Result, Hi} !== {5'b01000, 32'h0}) begin
            failures++;
            $display("[TB] FAIL reset_mid_mul got v=%b rdy=%b z=%b o=%b c=%b r=%h hi=%h exp v=0 rdy=1 flags=000 r=0000 hi=0000",
                     OutValid, InReady, Zero, Overflow, CarryOut, Result, Hi);
        end
        step();
        checks++;
        if (OutValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_mul_idle got v=%b exp v=0", OutValid);
        end
        issue(4'd2, 16'h0002, 16'h0003);
        checks++;
        if ({OutValid, Result} !== {1'b1, 16'h0005}) begin
            failures++;
            $display("[TB] FAIL reset_recover got v=%b r=%h exp v=1 r=0005", OutValid, Result);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_logic_shift();
        test_muldiv();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
